// File: rtl/nand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_pkg
// Description : Shared operation codes, FSM state codes and 24 MHz default
//               pin timings for the NAND bus-cycle engine.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_pkg;

    localparam logic [2:0] c_OP_CMD     = 3'd0;
    localparam logic [2:0] c_OP_ADDR    = 3'd1;
    localparam logic [2:0] c_OP_WRITE   = 3'd2;
    localparam logic [2:0] c_OP_READ    = 3'd3;
    localparam logic [2:0] c_OP_WAIT_RB = 3'd4;
    localparam logic [2:0] c_OP_CE_OFF  = 3'd5;

    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WLOW   = 3'd1;
    localparam logic [2:0] c_ST_WHIGH  = 3'd2;
    localparam logic [2:0] c_ST_RLOW   = 3'd3;
    localparam logic [2:0] c_ST_RHIGH  = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_WRB    = 3'd6;

    localparam int c_TWP_24M  = 2;
    localparam int c_TWH_24M  = 2;
    localparam int c_TRP_24M  = 2;
    localparam int c_TREH_24M = 2;
    localparam int c_TWB_24M  = 4;
    localparam int c_TO_W_24M = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_rb_sync.sv
`default_nettype none
// ============================================================================
// Module      : nand_rb_sync
// Description : Two-flop synchroniser for the asynchronous R/B# pin; resets
//               to "ready" so the engine never sees a false busy level.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_rb_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rb_n,
    output logic o_rb_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rb_n};
        end
    end

    assign o_rb_sync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/nand_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module      : nand_bus_cycle
// Description : Single-byte NAND Flash bus-cycle engine turning one sequencer
//               operation at a time into timed CLE/ALE/WE#/RE#/CE# activity.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_bus_cycle
    import nand_pkg::*;
#(
    parameter int TWP  = c_TWP_24M,
    parameter int TWH  = c_TWH_24M,
    parameter int TRP  = c_TRP_24M,
    parameter int TREH = c_TREH_24M,
    parameter int TWB  = c_TWB_24M,
    parameter int TO_W = c_TO_W_24M
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_type,
    input  logic [7:0] op_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_err,
    output logic       nand_ce_n,
    output logic       nand_cle,
    output logic       nand_ale,
    output logic       nand_we_n,
    output logic       nand_re_n,
    output logic [7:0] nand_io_out,
    output logic       nand_io_oe,
    input  logic [7:0] nand_io_in,
    input  logic       nand_rb_n
);

    localparam int              c_CW      = max_int(TO_W, 8);
    // Last count before the timeout value 2^TO_W-1 is reached.
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((64'd1 << TO_W) - 64'd2);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [2:0]        r_op_type;
    logic [2:0]        w_type;
    logic              w_accept;
    logic              w_timeout;
    logic              w_rd_capture;
    logic              w_in_write;
    logic              w_rb_sync;

    logic              r_op_ready;
    logic              r_rd_valid;
    logic [7:0]        r_rd_data;
    logic              r_busy_err;
    logic              r_ce_n;
    logic              r_cle;
    logic              r_ale;
    logic              r_we_n;
    logic              r_re_n;
    logic [7:0]        r_io_out;
    logic              r_io_oe;

    nand_rb_sync u_rb_sync (
        .clk       (clk),
        .rst       (rst),
        .i_rb_n    (nand_rb_n),
        .o_rb_sync (w_rb_sync)
    );

    // One counter serves every phase: phase widths count down to zero, while
    // the R/B# timeout counts up from zero inside WRB.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_timeout    = 1'b0;
        w_rd_capture = 1'b0;
        w_accept     = op_valid && r_op_ready;
        w_type       = w_accept ? op_type : r_op_type;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    case (op_type)
                        c_OP_CMD, c_OP_ADDR, c_OP_WRITE: begin
                            w_state_nxt = c_ST_WLOW;
                            w_cnt_nxt   = c_CW'(TWP - 1);
                        end
                        c_OP_READ: begin
                            w_state_nxt = c_ST_RLOW;
                            w_cnt_nxt   = c_CW'(TRP - 1);
                        end
                        c_OP_WAIT_RB: begin
                            w_state_nxt = c_ST_WB;
                            w_cnt_nxt   = c_CW'(TWB - 1);
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_WLOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_WHIGH;
                    w_cnt_nxt   = c_CW'(TWH - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_WHIGH: begin
                if (r_cnt == '0) w_state_nxt = c_ST_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            c_ST_RLOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = c_ST_RHIGH;
                    w_cnt_nxt    = c_CW'(TREH - 1);
                    w_rd_capture = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_RHIGH: begin
                if (r_cnt == '0) w_state_nxt = c_ST_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            c_ST_WB: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_WRB;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_WRB: begin
                if (w_rb_sync) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_in_write = (w_state_nxt == c_ST_WLOW) || (w_state_nxt == c_ST_WHIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_op_type  <= c_OP_CMD;
            r_op_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_busy_err <= 1'b0;
            r_ce_n     <= 1'b1;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_we_n     <= 1'b1;
            r_re_n     <= 1'b1;
            r_io_out   <= 8'h00;
            r_io_oe    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op_type  <= w_type;
            r_op_ready <= (w_state_nxt == c_ST_IDLE);
            r_rd_valid <= (r_state == c_ST_RHIGH) && (w_state_nxt == c_ST_IDLE);
            r_busy_err <= w_timeout;
            r_cle      <= w_in_write && (w_type == c_OP_CMD);
            r_ale      <= w_in_write && (w_type == c_OP_ADDR);
            r_io_oe    <= w_in_write;
            r_we_n     <= (w_state_nxt != c_ST_WLOW);
            r_re_n     <= (w_state_nxt != c_ST_RLOW);
            if (w_rd_capture) r_rd_data <= nand_io_in;
            // Reserved types leave CE# where it was.
            if (w_accept) begin
                if (op_type == c_OP_CE_OFF)       r_ce_n <= 1'b1;
                else if (op_type <= c_OP_WAIT_RB) r_ce_n <= 1'b0;
            end
            if (w_accept && (op_type <= c_OP_WRITE)) r_io_out <= op_data;
        end
    end

    assign op_ready    = r_op_ready;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign busy_err    = r_busy_err;
    assign nand_ce_n   = r_ce_n;
    assign nand_cle    = r_cle;
    assign nand_ale    = r_ale;
    assign nand_we_n   = r_we_n;
    assign nand_re_n   = r_re_n;
    assign nand_io_out = r_io_out;
    assign nand_io_oe  = r_io_oe;

endmodule
`default_nettype wire
